// File: rtl/ex_alu_unit.sv
// ex_alu_unit: registered EX-stage arithmetic unit for the RV32I pipeline.
// Decodes ALU class + func3/func7 into a 4-bit operation, computes the 32-bit
// result and the branch-taken mark, and registers both with one cycle latency.
// Optional build macro: ALU_TRACE_EN prints one line per accepted op in
// simulation; it has no functional or timing effect.
module ex_alu_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        valid_i,
    input  logic [2:0]  alu_op,
    input  logic [2:0]  func3,
    input  logic        func7,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    output logic        valid_o,
    output logic [31:0] alu_o,
    output logic        br_mark
);

    // Pipeline ALU classes
    localparam logic [2:0] CLS_ADD = 3'b000;
    localparam logic [2:0] CLS_BR  = 3'b001;
    localparam logic [2:0] CLS_R   = 3'b010;
    localparam logic [2:0] CLS_I   = 3'b011;

    // Internal operation codes
    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_SLL  = 4'd2;
    localparam logic [3:0] OP_SLT  = 4'd3;
    localparam logic [3:0] OP_SLTU = 4'd4;
    localparam logic [3:0] OP_XOR  = 4'd5;
    localparam logic [3:0] OP_SRL  = 4'd6;
    localparam logic [3:0] OP_SRA  = 4'd7;
    localparam logic [3:0] OP_OR   = 4'd8;
    localparam logic [3:0] OP_AND  = 4'd9;
    localparam logic [3:0] OP_BEQ  = 4'd10;
    localparam logic [3:0] OP_BNE  = 4'd11;
    localparam logic [3:0] OP_BLT  = 4'd12;
    localparam logic [3:0] OP_BGE  = 4'd13;
    localparam logic [3:0] OP_BLTU = 4'd14;
    localparam logic [3:0] OP_BGEU = 4'd15;

    // Signed two's-complement less-than
    function automatic logic f_lt_s(input logic signed [31:0] a, input logic signed [31:0] b);
        return a < b;
    endfunction

    // Unsigned less-than
    function automatic logic f_lt_u(input logic [31:0] a, input logic [31:0] b);
        return a < b;
    endfunction

    logic [3:0]         w_code;
    logic               w_br_illegal;
    logic [31:0]        w_result;
    logic               w_mark;
    logic [4:0]         w_shamt;
    logic signed [31:0] w_a_s;
    logic signed [31:0] w_b_s;

    logic               r_valid_p1;
    logic [31:0]        r_alu_p1;
    logic               r_br_p1;

    assign w_shamt = op_b[4:0];
    assign w_a_s   = op_a;
    assign w_b_s   = op_b;

    // Decode ALU class and func fields into the internal operation code.
    // Branch func3 010/011 have no code of their own; they are flagged so the
    // mark is suppressed while alu_o still reads zero like any branch.
    always_comb begin
        w_code       = OP_ADD;
        w_br_illegal = 1'b0;
        case (alu_op)
            CLS_BR: begin
                case (func3)
                    3'b000:  w_code = OP_BEQ;
                    3'b001:  w_code = OP_BNE;
                    3'b100:  w_code = OP_BLT;
                    3'b101:  w_code = OP_BGE;
                    3'b110:  w_code = OP_BLTU;
                    3'b111:  w_code = OP_BGEU;
                    default: begin
                        w_code       = OP_BEQ;
                        w_br_illegal = 1'b1;
                    end
                endcase
            end
            CLS_R, CLS_I: begin
                case (func3)
                    3'b000:  w_code = (alu_op == CLS_R && func7) ? OP_SUB : OP_ADD;
                    3'b001:  w_code = OP_SLL;
                    3'b010:  w_code = OP_SLT;
                    3'b011:  w_code = OP_SLTU;
                    3'b100:  w_code = OP_XOR;
                    3'b101:  w_code = func7 ? OP_SRA : OP_SRL;
                    3'b110:  w_code = OP_OR;
                    default: w_code = OP_AND;
                endcase
            end
            default: w_code = OP_ADD;  // CLS_ADD and reserved classes 100-111
        endcase
    end

    // Compute result and branch mark for the decoded operation
    always_comb begin
        w_result = 32'd0;
        w_mark   = 1'b0;
        case (w_code)
            OP_ADD:  w_result = op_a + op_b;
            OP_SUB:  w_result = op_a - op_b;
            OP_SLL:  w_result = op_a << w_shamt;
            OP_SLT:  w_result = {31'd0, f_lt_s(w_a_s, w_b_s)};
            OP_SLTU: w_result = {31'd0, f_lt_u(op_a, op_b)};
            OP_XOR:  w_result = op_a ^ op_b;
            OP_SRL:  w_result = op_a >> w_shamt;
            OP_SRA:  w_result = w_a_s >>> w_shamt;
            OP_OR:   w_result = op_a | op_b;
            OP_AND:  w_result = op_a & op_b;
            OP_BEQ:  w_mark = (op_a == op_b) && !w_br_illegal;
            OP_BNE:  w_mark = (op_a != op_b);
            OP_BLT:  w_mark = f_lt_s(w_a_s, w_b_s);
            OP_BGE:  w_mark = !f_lt_s(w_a_s, w_b_s);
            OP_BLTU: w_mark = f_lt_u(op_a, op_b);
            default: w_mark = !f_lt_u(op_a, op_b);  // OP_BGEU
        endcase
    end

    // Output register: result held on bubbles, branch mark cleared so a stale
    // taken flag never outlives its operation
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid_p1 <= 1'b0;
            r_alu_p1   <= 32'd0;
            r_br_p1    <= 1'b0;
        end else begin
            r_valid_p1 <= valid_i;
            if (valid_i) begin
                r_alu_p1 <= w_result;
                r_br_p1  <= w_mark;
            end else begin
                r_br_p1  <= 1'b0;
            end
        end
    end

`ifdef ALU_TRACE_EN
    // Simulation trace of every accepted operation
    always_ff @(posedge clk) begin
        if (rst_n && valid_i)
            $display("ex_alu_unit: code=%0d a=%08h b=%08h result=%08h br=%0b",
                     w_code, op_a, op_b, w_result, w_mark);
    end
`endif

    assign valid_o = r_valid_p1;
    assign alu_o   = r_alu_p1;
    assign br_mark = r_br_p1;

endmodule

// File: tb/tb_ex_alu_unit.sv
// Directed bench for ex_alu_unit: expected outputs are queued when an op is
// driven and compared one cycle later when the DUT presents them.
module tb_ex_alu_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid_i;
    logic [2:0]  alu_op;
    logic [2:0]  func3;
    logic        func7;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        valid_o;
    logic [31:0] alu_o;
    logic        br_mark;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        v;
        logic [31:0] alu;
        logic        br;
        string       tag;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    ex_alu_unit dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .valid_i (valid_i),
        .alu_op  (alu_op),
        .func3   (func3),
        .func7   (func7),
        .op_a    (op_a),
        .op_b    (op_b),
        .valid_o (valid_o),
        .alu_o   (alu_o),
        .br_mark (br_mark)
    );

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
        end
    endtask

    // Drive one op at the falling edge, queue its expectation, then compare
    // after the capturing rising edge.
    task automatic step(input string tag, input logic v, input logic [2:0] op,
                        input logic [2:0] f3, input logic f7,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_alu, input logic exp_br);
        exp_t e;
        @(negedge clk);
        valid_i = v;
        alu_op  = op;
        func3   = f3;
        func7   = f7;
        op_a    = a;
        op_b    = b;
        e.v = v; e.alu = exp_alu; e.br = exp_br; e.tag = tag;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s: observed empty scoreboard expected entry", tag);
        end else begin
            e = sb.pop_front();
            chk1 ({e.tag, ".valid"}, valid_o, e.v);
            chk32({e.tag, ".alu"},   alu_o,   e.alu);
            chk1 ({e.tag, ".br"},    br_mark, e.br);
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        valid_i = 1'b1;
        alu_op  = 3'b000;
        func3   = 3'b000;
        func7   = 1'b0;
        op_a    = 32'd5;
        op_b    = 32'd7;

        // Reset held across edges with a valid op on the inputs
        repeat (2) @(posedge clk);
        #1;
        chk1 ("rst.valid", valid_o, 1'b0);
        chk32("rst.alu",   alu_o,   32'd0);
        chk1 ("rst.br",    br_mark, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        step("add_after_rst", 1, 3'b000, 3'b000, 0, 32'd5, 32'd7, 32'd12, 0);

        // R-type vs I-type func7 on func3=000
        step("r_sub",  1, 3'b010, 3'b000, 1, 32'd3, 32'd5, 32'hFFFF_FFFE, 0);
        step("i_add",  1, 3'b011, 3'b000, 1, 32'd3, 32'd5, 32'd8, 0);

        // Shifts use op_b[4:0] only
        step("srl",  1, 3'b010, 3'b101, 0, 32'h8000_0000, 32'h24, 32'h0800_0000, 0);
        step("sra",  1, 3'b010, 3'b101, 1, 32'h8000_0000, 32'h24, 32'hF800_0000, 0);
        step("sll",  1, 3'b010, 3'b001, 0, 32'h8000_0000, 32'h24, 32'h0000_0000, 0);
        step("srai", 1, 3'b011, 3'b101, 1, 32'h8000_0000, 32'h24, 32'hF800_0000, 0);

        // Logic ops
        step("xor",  1, 3'b010, 3'b100, 0, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_0FF0, 0);
        step("or",   1, 3'b011, 3'b110, 0, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_FFF0, 0);
        step("and",  1, 3'b010, 3'b111, 0, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000, 0);

        // Signed vs unsigned compares
        step("slt",  1, 3'b010, 3'b010, 0, 32'hFFFF_FFFF, 32'd1, 32'd1, 0);
        step("sltu", 1, 3'b010, 3'b011, 0, 32'hFFFF_FFFF, 32'd1, 32'd0, 0);
        step("blt",  1, 3'b001, 3'b100, 0, 32'hFFFF_FFFF, 32'd1, 32'd0, 1);
        step("bltu", 1, 3'b001, 3'b110, 0, 32'hFFFF_FFFF, 32'd1, 32'd0, 0);
        step("bge",  1, 3'b001, 3'b101, 0, 32'hFFFF_FFFF, 32'd1, 32'd0, 0);
        step("bgeu", 1, 3'b001, 3'b111, 0, 32'hFFFF_FFFF, 32'd1, 32'd0, 1);

        // Equality branches, illegal branch func3, ADD class link +4
        step("beq",    1, 3'b001, 3'b000, 0, 32'h1234, 32'h1234, 32'd0, 1);
        step("bne",    1, 3'b001, 3'b001, 0, 32'h1234, 32'h1234, 32'd0, 0);
        step("br_010", 1, 3'b001, 3'b010, 0, 32'h1234, 32'h1234, 32'd0, 0);
        step("br_011", 1, 3'b001, 3'b011, 0, 32'h1234, 32'h1235, 32'd0, 0);
        step("link4",  1, 3'b000, 3'b000, 0, 32'h1234, 32'd4, 32'h1238, 0);
        step("cls111", 1, 3'b111, 3'b000, 1, 32'd3, 32'd5, 32'd8, 0);

        // Valid gating: taken branch then bubble, then result held over bubble
        step("beq_t",  1, 3'b001, 3'b000, 0, 32'd9, 32'd9, 32'd0, 1);
        step("bubble1",0, 3'b001, 3'b000, 0, 32'd9, 32'd9, 32'd0, 0);
        step("add30",  1, 3'b000, 3'b000, 0, 32'h10, 32'h20, 32'h30, 0);
        step("bubble2",0, 3'b010, 3'b000, 1, 32'd1, 32'd1, 32'h30, 0);

        // Asynchronous reset mid-stream, between edges
        step("pre_rst", 1, 3'b001, 3'b000, 0, 32'd7, 32'd7, 32'd0, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk1 ("mid_rst.valid", valid_o, 1'b0);
        chk32("mid_rst.alu",   alu_o,   32'd0);
        chk1 ("mid_rst.br",    br_mark, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        step("post_rst", 1, 3'b000, 3'b000, 0, 32'd5, 32'd7, 32'd12, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
